// File: rtl/pad_gpio_pkg.sv
// Shared types for the GPIO pad controller: sequencer states and the
// per-pad configuration record driven onto the pad cell.
package pad_gpio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_PRELOAD,
      ST_ENABLE,
      ST_DISABLE,
      ST_PULL
   } state_t;

   typedef struct packed {
      logic oen;
      logic i;
      logic pen;
      logic puen;
   } pad_cfg_t;

   localparam pad_cfg_t PAD_RESET = '{oen: 1'b1, i: 1'b0, pen: 1'b1, puen: 1'b0};

   // Pad cell pull controls are active-low enable and low-means-pull-up.
   function automatic pad_cfg_t make_cfg(input logic oen, input logic drv,
                                         input logic pull_en, input logic pull_up);
      pad_cfg_t c;
      c.oen  = oen;
      c.i    = drv;
      c.pen  = ~pull_en;
      c.puen = ~pull_up;
      return c;
   endfunction

endpackage

// File: rtl/pad_gpio_ctrl_filter.sv
// Per-pad input path: two-flop synchronizer, plus a stability debounce
// when PAD_GPIO_DEBOUNCE_EN is defined (otherwise level = synchronizer out).
module pad_in_filter #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw,
   output logic level
);

   if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_deb
      $error("pad_in_filter: DEB_CYCLES must be within 1..255");
   end

   logic sync1;
   logic sync2;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

`ifdef PAD_GPIO_DEBOUNCE_EN
   logic [7:0] cnt;
   logic       lvl;

   // Any cycle where the synced value agrees with the output restarts the count.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt <= '0;
         lvl <= 1'b0;
      end else if (sync2 == lvl) begin
         cnt <= '0;
      end else if (cnt == 8'(DEB_CYCLES - 1)) begin
         cnt <= '0;
         lvl <= sync2;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

   assign level = lvl;
`else
   assign level = sync2;
`endif

endmodule

// File: rtl/pad_gpio_ctrl.sv
// GPIO pad controller: sequences direction changes break-before-make and
// filters pad readback. Optional debounce via PAD_GPIO_DEBOUNCE_EN.
//
//   state      | meaning
//   IDLE       | ready for a request
//   APPLY      | direction unchanged, all target fields written
//   PRELOAD    | in->out: drive value and pulls set, still tri-stated
//   ENABLE     | in->out: output driver enabled
//   DISABLE    | out->in: output driver released, drive value held
//   PULL       | out->in: pulls and drive value written
module pad_gpio_ctrl
   import pad_gpio_pkg::*;
#(
   parameter  int NUM_PADS   = 8,
   parameter  int DEB_CYCLES = 4,
   localparam int IDX_W      = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   input  logic [IDX_W-1:0]    cfg_idx_i,
   input  logic                cfg_dir_out_i,
   input  logic                cfg_out_i,
   input  logic                cfg_pull_en_i,
   input  logic                cfg_pull_up_i,
   output logic [NUM_PADS-1:0] pad_oen_o,
   output logic [NUM_PADS-1:0] pad_i_o,
   output logic [NUM_PADS-1:0] pad_pen_o,
   output logic [NUM_PADS-1:0] pad_puen_o,
   input  logic [NUM_PADS-1:0] pad_o_i,
   output logic [NUM_PADS-1:0] in_val_o,
   output logic [NUM_PADS-1:0] edge_o
);

   if (NUM_PADS < 1 || NUM_PADS > 32) begin : g_bad_pads
      $error("pad_gpio_ctrl: NUM_PADS must be within 1..32");
   end

   state_t              state;
   pad_cfg_t            pads [NUM_PADS];
   logic [IDX_W-1:0]    idx;
   logic                drv;
   logic                pull_en;
   logic                pull_up;
   logic [NUM_PADS-1:0] hit_new;
   logic [NUM_PADS-1:0] hit_req;
   logic                cur_oen;
   logic                flip;
   logic [NUM_PADS-1:0] val_d;
   logic [NUM_PADS-1:0] edge_q;

   // An all-zero hit_new means the index is past the last pad.
   always_comb begin
      hit_new = '0;
      hit_req = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
         hit_new[p] = (cfg_idx_i == IDX_W'(p));
         hit_req[p] = (idx == IDX_W'(p));
      end
   end

   assign cur_oen     = |(hit_new & pad_oen_o);
   assign flip        = (cfg_dir_out_i == cur_oen);
   assign cfg_ready_o = (state == ST_IDLE);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= ST_IDLE;
         idx     <= '0;
         drv     <= 1'b0;
         pull_en <= 1'b0;
         pull_up <= 1'b0;
         for (int p = 0; p < NUM_PADS; p++) pads[p] <= PAD_RESET;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_valid_i && |hit_new) begin
                  idx     <= cfg_idx_i;
                  drv     <= cfg_out_i;
                  pull_en <= cfg_pull_en_i;
                  pull_up <= cfg_pull_up_i;
                  for (int p = 0; p < NUM_PADS; p++) begin
                     if (hit_new[p]) begin
                        if (!flip)
                           pads[p] <= make_cfg(~cfg_dir_out_i, cfg_out_i, cfg_pull_en_i, cfg_pull_up_i);
                        else if (cfg_dir_out_i)
                           pads[p] <= make_cfg(1'b1, cfg_out_i, cfg_pull_en_i, cfg_pull_up_i);
                        else
                           pads[p].oen <= 1'b1;
                     end
                  end
                  state <= !flip ? ST_APPLY : (cfg_dir_out_i ? ST_PRELOAD : ST_DISABLE);
               end
            end
            ST_PRELOAD: begin
               for (int p = 0; p < NUM_PADS; p++)
                  if (hit_req[p]) pads[p].oen <= 1'b0;
               state <= ST_ENABLE;
            end
            ST_DISABLE: begin
               for (int p = 0; p < NUM_PADS; p++)
                  if (hit_req[p]) pads[p] <= make_cfg(1'b1, drv, pull_en, pull_up);
               state <= ST_PULL;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      assign pad_oen_o[p]  = pads[p].oen;
      assign pad_i_o[p]    = pads[p].i;
      assign pad_pen_o[p]  = pads[p].pen;
      assign pad_puen_o[p] = pads[p].puen;

      pad_in_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filter (
         .clk_i (clk_i),
         .rst_ni(rst_ni),
         .raw   (pad_o_i[p]),
         .level (in_val_o[p])
      );
   end

   // Edges are reported one cycle after the level moves, masked for driven pads.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         val_d  <= '0;
         edge_q <= '0;
      end else begin
         val_d  <= in_val_o;
         edge_q <= (in_val_o ^ val_d) & pad_oen_o;
      end
   end

   assign edge_o = edge_q;

endmodule
